pc_gen_unit: RTL

- Parametrised next-generation program-counter generator for the instruction-fetch stage.
- Produces a sequential fetch address with a valid/ready handshake toward instruction memory.
- Accepts prioritised redirects (exception, branch), a pipeline stall and a halt request, all from later stages.
- Replaces the fixed free-running PC register and adds a configurable reset vector, step size and alignment checking.

---
 rtl/pc_gen_unit_if.sv | 27 ++
 rtl/pc_gen_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/pc_gen_unit_if.sv
// Fetch-address handshake plus redirect/stall/halt controls for pc_gen_unit.
// master = PC generator, slave = fetch side and later pipeline stages.
interface pc_gen_unit_if #(
  parameter int InstAddrBus = 32
);
  logic [InstAddrBus-1:0] gen_pc;
  logic                   gen_pc_vld;
  logic                   gen_pc_rdy;
  logic                   stall;
  logic                   br_vld;
  logic [InstAddrBus-1:0] br_target;
  logic                   exc_vld;
  logic [InstAddrBus-1:0] exc_target;
  logic                   halt_req;
  logic                   halted;
  logic                   align_err;

  modport master (
    output gen_pc, gen_pc_vld, halted, align_err,
    input  gen_pc_rdy, stall, br_vld, br_target, exc_vld, exc_target, halt_req
  );

  modport slave (
    input  gen_pc, gen_pc_vld, halted, align_err,
    output gen_pc_rdy, stall, br_vld, br_target, exc_vld, exc_target, halt_req
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Instruction-fetch program-counter generator: sequential stepping with a
// valid/ready handshake, prioritised exception/branch redirects, stall and halt.
module pc_gen_unit #(
  parameter int                     InstAddrBus = 32,
  parameter int                     InstBytes   = 4,
  parameter logic [InstAddrBus-1:0] ResetVector = {InstAddrBus{1'b0}}
) (
  input logic           clk,
  input logic           rst,
  pc_gen_unit_if.master bus
);

  localparam logic [InstAddrBus-1:0] Step    = InstAddrBus'(InstBytes);
  localparam logic [InstAddrBus-1:0] LowMask = InstAddrBus'(InstBytes - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   halted_q, halted_d;
  logic                   align_err_q, align_err_d;

  logic                   redir_s;
  logic [InstAddrBus-1:0] target_s;
  logic                   vld_s;

  // Valid depends only on the registered state and the current stall.
  assign vld_s    = (state_q == ST_RUN) && !bus.stall;
  // Exception wins over branch; only the winning target is alignment-checked.
  assign redir_s  = bus.exc_vld || bus.br_vld;
  assign target_s = bus.exc_vld ? bus.exc_target : bus.br_target;

  // Next-state, next-PC and alignment-flag selection in priority order.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    align_err_d = 1'b0;
    if (redir_s) begin
      pc_d        = target_s & ~LowMask;
      align_err_d = |(target_s & LowMask);
      state_d     = ST_RUN;
    end else if ((state_q == ST_RUN) && bus.halt_req) begin
      state_d = ST_HALT;
    end else begin
      if (vld_s && bus.gen_pc_rdy) begin
        pc_d = pc_q + Step;
      end else begin
        pc_d = pc_q;
      end
      if (state_q == ST_BOOT) begin
        state_d = ST_RUN;
      end else begin
        state_d = state_q;
      end
    end
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= ResetVector;
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.gen_pc     = pc_q;
  assign bus.gen_pc_vld = vld_s;
  assign bus.halted     = halted_q;
  assign bus.align_err  = align_err_q;

endmodule
